// File: rtl/second_layer_tnndirect_pkg.sv
// Shared widths and FSM encoding for the ternary output layer.
package second_layer_tnndirect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ARGMAX,
        ST_DONE
    } state_t;

    // Signed score must span -n..+n.
    function automatic int score_bits(input int n);
        return $clog2(n + 1) + 1;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/second_layer_tnndirect_if.sv
// Handshake and result bundle between the hidden layer and the output layer.
interface second_layer_tnndirect_if
    import second_layer_tnndirect_pkg::*;
#(
    parameter int HIDDEN_CNT = 4,
    parameter int CLASS_CNT  = 3
);
    logic                                           start;
    logic [HIDDEN_CNT-1:0]                          hidden;
    logic [CLASS_CNT*score_bits(HIDDEN_CNT)-1:0]    scores;
    logic [clog2_min1(CLASS_CNT)-1:0]               out_class;
    logic                                           done;

    modport master (output start, hidden, input scores, out_class, done);
    modport slave  (input start, hidden, output scores, out_class, done);
endinterface

// File: rtl/second_layer_tnndirect_class_scorer.sv
// One class accumulator: adds -1/0/+1 per streamed hidden bit.
module class_scorer_tnndirect
    import second_layer_tnndirect_pkg::*;
#(
    parameter int                    HIDDEN_CNT = 4,
    parameter logic [HIDDEN_CNT-1:0] SIGNS      = '0,
    parameter logic [HIDDEN_CNT-1:0] NZ         = '0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clr,
    input  logic                                      en,
    input  logic [clog2_min1(HIDDEN_CNT)-1:0]         cnt,
    input  logic                                      hbit,
    output logic signed [score_bits(HIDDEN_CNT)-1:0]  score
);
    localparam int SB = score_bits(HIDDEN_CNT);

    logic signed [SB-1:0] delta;

    // Matching sign and hidden bit contribute +1, mismatch -1.
    assign delta = (hbit ~^ SIGNS[cnt]) ? SB'(1) : {SB{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score <= '0;
        else if (clr)
            score <= '0;
        else if (en && NZ[cnt])
            score <= score + delta;
    end
endmodule

// File: rtl/second_layer_tnndirect.sv
// Ternary output layer: latches the hidden vector, accumulates class scores, then argmax.
module second_layer_tnndirect
    import second_layer_tnndirect_pkg::*;
#(
    parameter int                               HIDDEN_CNT  = 4,
    parameter int                               CLASS_CNT   = 3,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]  SPARSE_VALS = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]  MASK        = '0
) (
    input logic                   clk,
    input logic                   rst,
    second_layer_tnndirect_if.slave bus
);
    localparam int SB       = score_bits(HIDDEN_CNT);
    localparam int CNT_BITS = clog2_min1(HIDDEN_CNT);
    localparam int IDX_BITS = clog2_min1(CLASS_CNT);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(HIDDEN_CNT - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(CLASS_CNT - 1);

    state_t                          state_q, state_d;
    logic [HIDDEN_CNT-1:0]           hreg;
    logic [CNT_BITS-1:0]             cnt;
    logic [IDX_BITS-1:0]             idx, best_idx;
    logic signed [SB-1:0]            best;
    logic [CLASS_CNT-1:0][SB-1:0]    score_arr;
    logic                            clr, en;

    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_class
        class_scorer_tnndirect #(
            .HIDDEN_CNT (HIDDEN_CNT),
            .SIGNS      (SPARSE_VALS[c*HIDDEN_CNT +: HIDDEN_CNT]),
            .NZ         (MASK[c*HIDDEN_CNT +: HIDDEN_CNT])
        ) u_scorer (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (en),
            .cnt   (cnt),
            .hbit  (hreg[cnt]),
            .score (score_arr[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                en = 1'b1;
                if (cnt == CNT_LAST) state_d = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                if (idx == IDX_LAST) state_d = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hreg     <= '0;
            cnt      <= '0;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) hreg <= bus.hidden;
                    cnt <= '0;
                    idx <= '0;
                end
                ST_ACCUM: begin
                    cnt <= cnt + 1'b1;
                    idx <= '0;
                end
                ST_ARGMAX: begin
                    // Strict > keeps the lowest index on ties.
                    if (idx == '0 || $signed(score_arr[idx]) > best) begin
                        best     <= $signed(score_arr[idx]);
                        best_idx <= idx;
                    end
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.scores    = score_arr;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.out_class = (state_q == ST_DONE) ? best_idx : '0;
endmodule

// File: tb/tb_second_layer_tnndirect.sv
// Randomized and directed checks of the ternary output layer against a sum/argmax model.
module tb_second_layer_tnndirect;
    localparam int H  = 4;
    localparam int C  = 3;
    localparam int SB = 4;
    // Bit c*H+j holds class c, hidden j.
    localparam logic [C*H-1:0] MASK_A = {4'b0101, 4'b1111, 4'b1111};
    localparam logic [C*H-1:0] SIGN_A = {4'b0100, 4'b0000, 4'b1111};
    localparam logic [C*H-1:0] MASK_B = {4'b1111, 4'b1111, 4'b1111};
    localparam logic [C*H-1:0] SIGN_B = {4'b0011, 4'b0000, 4'b1111};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    second_layer_tnndirect_if #(.HIDDEN_CNT(H), .CLASS_CNT(C)) bus_a ();
    second_layer_tnndirect_if #(.HIDDEN_CNT(H), .CLASS_CNT(C)) bus_b ();

    second_layer_tnndirect #(.HIDDEN_CNT(H), .CLASS_CNT(C), .SPARSE_VALS(SIGN_A), .MASK(MASK_A))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    second_layer_tnndirect #(.HIDDEN_CNT(H), .CLASS_CNT(C), .SPARSE_VALS(SIGN_B), .MASK(MASK_B))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    function automatic int ref_score(input logic [C*H-1:0] mk, input logic [C*H-1:0] sg,
                                     input logic [H-1:0] h, input int c);
        int s = 0;
        for (int j = 0; j < H; j++)
            if (mk[c*H+j]) s += (h[j] == sg[c*H+j]) ? 1 : -1;
        return s;
    endfunction

    function automatic int ref_class(input logic [C*H-1:0] mk, input logic [C*H-1:0] sg,
                                     input logic [H-1:0] h);
        int b = 0;
        for (int c = 1; c < C; c++)
            if (ref_score(mk, sg, h, c) > ref_score(mk, sg, h, b)) b = c;
        return b;
    endfunction

    function automatic int get_score(input logic [C*SB-1:0] v, input int c);
        logic signed [SB-1:0] s;
        s = v[c*SB +: SB];
        return int'(s);
    endfunction

    task automatic drive(input logic s, input logic [H-1:0] h);
        bus_a.start = s; bus_a.hidden = h;
        bus_b.start = s; bus_b.hidden = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Latch edge counts as edge 1; done must be low after edge 7 and high after edge 8.
    task automatic test_vector(input string name, input logic [H-1:0] h);
        logic [C*SB-1:0] sc [2];
        logic [1:0]      oc [2];
        logic [C*H-1:0]  mk [2];
        logic [C*H-1:0]  sg [2];
        mk[0] = MASK_A; sg[0] = SIGN_A; mk[1] = MASK_B; sg[1] = SIGN_B;
        do_reset();
        drive(1'b1, h);
        repeat (7) @(posedge clk);
        @(negedge clk);
        drive(1'b1, ~h);
        vectors++;
        if (bus_a.done !== 1'b0 || bus_b.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_done: got a=%b b=%b want 0", name, bus_a.done, bus_b.done);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus_a.done !== 1'b1 || bus_b.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_edge8: got a=%b b=%b want 1", name, bus_a.done, bus_b.done);
        end
        sc[0] = bus_a.scores; sc[1] = bus_b.scores;
        oc[0] = bus_a.out_class; oc[1] = bus_b.out_class;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < C; c++) begin
                vectors++;
                if (get_score(sc[d], c) !== ref_score(mk[d], sg[d], h, c)) begin
                    miscompares++;
                    $display("FAIL %s score dut%0d c%0d h=%b: got %0d want %0d", name, d, c, h,
                             get_score(sc[d], c), ref_score(mk[d], sg[d], h, c));
                end
            end
            vectors++;
            if (int'(oc[d]) !== ref_class(mk[d], sg[d], h)) begin
                miscompares++;
                $display("FAIL %s out_class dut%0d h=%b: got %0d want %0d", name, d, h,
                         oc[d], ref_class(mk[d], sg[d], h));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if (bus_a.done !== 1'b0 || bus_a.out_class !== 2'd0 || bus_a.scores !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got done=%b cls=%0d scores=%h want 0/0/0",
                     bus_a.done, bus_a.out_class, bus_a.scores);
        end
    endtask

    task automatic test_directed();
        test_vector("all_ones", 4'b1111);
        test_vector("all_zeros", 4'b0000);
        test_vector("tie_0011", 4'b0011);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) test_vector("random", 4'($urandom_range(0, 15)));
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 4'b1111);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus_a.done !== 1'b0 || bus_a.out_class !== 2'd0 || bus_a.scores !== '0 ||
            bus_b.scores !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got done=%b cls=%0d scores=%h/%h want all 0",
                     bus_a.done, bus_a.out_class, bus_a.scores, bus_b.scores);
        end
        @(negedge clk);
        rst = 1'b0;
        test_vector("restart_0000", 4'b0000);
    endtask

    task automatic test_hold_after_done();
        logic [C*SB-1:0] sc_ref;
        test_vector("pre_hold", 4'b0000);
        sc_ref = bus_a.scores;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(i[0], 4'($urandom_range(0, 15)));
            @(negedge clk);
            vectors++;
            if (bus_a.done !== 1'b1 || bus_a.out_class !== 2'd1 || bus_a.scores !== sc_ref) begin
                miscompares++;
                $display("FAIL hold_after_done: got done=%b cls=%0d scores=%h want 1/1/%h",
                         bus_a.done, bus_a.out_class, bus_a.scores, sc_ref);
            end
        end
    endtask

    initial begin
        drive(1'b0, '0);
        rst = 1'b1;
        #12 rst = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_mid_reset();
        test_hold_after_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
